// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   fetch_state_e     - FSM states of pc_fetch
//   PC_STEP           - byte distance between sequential instruction words
//   DEFAULT_RESET_PC  - PC loaded on reset unless overridden by the top
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding for pc
        HOLD  = 2'd1,   // instruction held for downstream, no request
        FLUSH = 2'd2    // abandoned request still draining from memory
    } fetch_state_e;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0080;

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// WIDTH-bit register with synchronous active-high reset to RST_VAL and a load
// enable. Used for the program counter and the held pc/instruction pair.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   en   - load enable
//   d    - value loaded when en=1
//   q    - registered value
// -----------------------------------------------------------------------------
module pc_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Instruction-fetch stage. Owns the program counter, issues one word-aligned
// read at a time to instruction memory over req/ack, and holds the returned
// instruction with its pc until downstream accepts it. Redirects take priority
// over sequential fetch and discard any in-flight or held work.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   imem_req/imem_addr    - read request and address to instruction memory
//   imem_ack/imem_rdata   - memory response (rdata valid when ack=1)
//   out_valid/out_ready   - handshake to the downstream stage
//   out_pc/out_ins        - held instruction address and word
//   redirect/redirect_pc  - branch/jump target load (low two bits dropped)
// -----------------------------------------------------------------------------
module pc_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_ins,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             pc_en;
    logic             cap_en;
    logic [WIDTH-1:0] flush_addr_q, flush_addr_d;
    logic [WIDTH-1:0] redirect_tgt;
    logic [WIDTH-1:0] pc_next_seq;

    assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
    assign pc_next_seq  = pc_q + WIDTH'(PC_STEP);

    pc_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc_q)
    );

    pc_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_out_pc (
        .clk (clk),
        .rst (rst),
        .en  (cap_en),
        .d   (pc_q),
        .q   (out_pc)
    );

    pc_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_out_ins (
        .clk (clk),
        .rst (rst),
        .en  (cap_en),
        .d   (imem_rdata),
        .q   (out_ins)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_en        = 1'b0;
        cap_en       = 1'b0;
        flush_addr_d = flush_addr_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d  = redirect_tgt;
                    pc_en = 1'b1;
                    // Without an ack the request must still complete at its
                    // original address, so remember it and drain in FLUSH.
                    if (!imem_ack) begin
                        flush_addr_d = pc_q;
                        state_d      = FLUSH;
                    end
                end else if (imem_ack) begin
                    cap_en  = 1'b1;
                    pc_d    = pc_next_seq;
                    pc_en   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A redirect drops the held word even if out_ready is high.
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end else if (out_ready) begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pc_d  = redirect_tgt;
                    pc_en = 1'b1;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // In-flight address only matters while in FLUSH; not reset.
    always_ff @(posedge clk) begin
        flush_addr_q <= flush_addr_d;
    end

    // The request is suppressed while reset is held so an outstanding
    // access is abandoned immediately.
    assign imem_req  = !rst && ((state_q == FETCH) || (state_q == FLUSH));
    assign imem_addr = (state_q == FLUSH) ? flush_addr_q : pc_q;
    assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Directed bench for pc_fetch: a default instance covering sequential fetch,
// back-pressure, redirects and mid-fetch reset, plus a second instance with
// RESET_PC at the top of the address space to cover pc wrap-around.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] XOR_PAT = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        auto_ack;
    logic        man_ack;

    logic        rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_pc2;
    logic [31:0] out_ins2;
    logic        redirect2;
    logic [31:0] redirect_pc2;

    int checks;
    int errors;

    // Memory model: zero-wait ack when auto_ack, otherwise manual ack.
    assign imem_ack    = auto_ack ? imem_req : (man_ack & imem_req);
    assign imem_rdata  = imem_addr ^ XOR_PAT;
    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = imem_addr2 ^ XOR_PAT;

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_ins     (out_ins),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    pc_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .rst         (rst2),
        .imem_req    (imem_req2),
        .imem_addr   (imem_addr2),
        .imem_ack    (imem_ack2),
        .imem_rdata  (imem_rdata2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_pc      (out_pc2),
        .out_ins     (out_ins2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        rst2         = 1'b1;
        out_ready    = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        auto_ack     = 1'b1;
        man_ack      = 1'b0;
        out_ready2   = 1'b1;
        redirect2    = 1'b0;
        redirect_pc2 = '0;

        // Reset state
        step();
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc",    out_pc,  32'd0);
        chk("rst_ins",   out_ins, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h80);

        // Sequential zero-wait fetch, out_ready=1
        step();
        chk("seq0_valid", {31'd0, out_valid}, 32'd1);
        chk("seq0_pc",    out_pc,  32'h80);
        chk("seq0_ins",   out_ins, 32'hA5A5_A525);
        chk("seq0_req",   {31'd0, imem_req}, 32'd0);
        step();
        chk("seq1_gap_valid", {31'd0, out_valid}, 32'd0);
        chk("seq1_addr",      imem_addr, 32'h84);
        step();
        chk("seq1_valid", {31'd0, out_valid}, 32'd1);
        chk("seq1_pc",    out_pc,  32'h84);
        chk("seq1_ins",   out_ins, 32'hA5A5_A521);

        // Back-pressure in HOLD for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_pc",    out_pc,  32'h84);
            chk("stall_ins",   out_ins, 32'hA5A5_A521);
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
        end

        // Accept, then fetch of 0x88 with memory stalled
        out_ready = 1'b1;
        auto_ack  = 1'b0;
        step();
        chk("acc_valid", {31'd0, out_valid}, 32'd0);
        chk("acc_req",   {31'd0, imem_req}, 32'd1);
        chk("acc_addr",  imem_addr, 32'h88);

        // Redirect to 0x203 while 0x88 is pending
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        chk("flush0_req",  {31'd0, imem_req}, 32'd1);
        chk("flush0_addr", imem_addr, 32'h88);
        step();
        chk("flush1_addr", imem_addr, 32'h88);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("post_flush_addr",  imem_addr, 32'h200);
        chk("post_flush_keep_pc", out_pc, 32'h84);
        auto_ack = 1'b1;
        step();
        chk("tgt_valid", {31'd0, out_valid}, 32'd1);
        chk("tgt_pc",    out_pc,  32'h200);
        chk("tgt_ins",   out_ins, 32'hA5A5_A7A5);

        // Redirect in HOLD with out_ready=1: held word dropped
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        chk("hold_rd_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_rd_addr",  imem_addr, 32'h400);
        step();
        chk("hold_rd_pc",  out_pc,  32'h400);
        chk("hold_rd_ins", out_ins, 32'hA5A5_A1A5);

        // Redirect in FETCH coinciding with ack: data discarded
        step();
        chk("fa_addr", imem_addr, 32'h404);
        redirect    = 1'b1;
        redirect_pc = 32'h600;
        step();
        redirect = 1'b0;
        chk("fa_valid",   {31'd0, out_valid}, 32'd0);
        chk("fa_addr2",   imem_addr, 32'h600);
        chk("fa_keep_pc", out_pc, 32'h400);
        step();
        chk("fa_pc",  out_pc,  32'h600);
        chk("fa_ins", out_ins, 32'hA5A5_A3A5);

        // Reset asserted mid-FETCH with ack delayed
        auto_ack = 1'b0;
        step();
        chk("mid_req_addr", imem_addr, 32'h604);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_now", {31'd0, imem_req}, 32'd0);
        step();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_pc",    out_pc, 32'd0);
        chk("mid_rst_req",   {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_req_after",  {31'd0, imem_req}, 32'd1);
        chk("mid_rst_addr_after", imem_addr, 32'h80);

        // Wrap-around instance
        rst2 = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc0",  out_pc2,  32'hFFFF_FFFC);
        chk("wrap_ins0", out_ins2, 32'h5A5A_5A59);
        step();
        chk("wrap_addr1", imem_addr2, 32'h0);
        step();
        chk("wrap_valid1", {31'd0, out_valid2}, 32'd1);
        chk("wrap_pc1",    out_pc2,  32'h0);
        chk("wrap_ins1",   out_ins2, 32'hA5A5_A5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
